// File: rtl/x8_approx_pkg.sv
// x8_approx_pkg: shared constants and FSM encoding for the approximate divider family.
package x8_approx_pkg;
  localparam int W = 8;
  localparam int ITER = 8;
  localparam logic [W-1:0] DIV0_Q = 8'hFF;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/x8_approx_sub.sv
// x8_approx_sub: 9-bit adder whose N4 low bits use an OR/AND approximate cell.
module x8_approx_sub
  import x8_approx_pkg::*;
#(
  parameter int N4 = 0
) (
  input  logic [W:0] a,
  input  logic [W:0] b,
  input  logic       cin,
  output logic [W:0] s,
  output logic       cout
);
  logic [W+1:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i <= W; i++) begin : g_bit
    if (i < N4) begin : g_apx
      // Approximate cell drops the incoming carry entirely.
      assign s[i] = a[i] | b[i];
      assign c[i+1] = a[i] & b[i];
    end else begin : g_fa
      assign s[i] = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end
  assign cout = c[W+1];
endmodule

// File: rtl/x8_approx_div.sv
// x8_approx_div: 8-bit restoring divider using an approximate trial subtractor.
// Define X8_APPROX_DIV_STATS_EN to add the op_count completion counter.
module x8_approx_div
  import x8_approx_pkg::*;
#(
  parameter int N4 = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
`ifdef X8_APPROX_DIV_STATS_EN
  ,
  output logic [15:0]  op_count
`endif
);
  logic [1:0] state;
  logic [3:0] cnt;
  logic [W-1:0] r, q, dvd, d;
  logic [W:0] r9, t;
  logic co, unused_msb;
  assign r9 = {r, dvd[W-1]};
  x8_approx_sub #(.N4(N4)) u_sub (.a(r9), .b(~{1'b0, d}), .cin(1'b1), .s(t), .cout(co));
  // Only R[7:0] feeds the next iteration, so the trial MSB is never stored.
  assign unused_msb = t[W];
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      r <= '0;
      q <= '0;
      dvd <= '0;
      d <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        state <= divisor == '0 ? DONE : CALC;
        q <= divisor == '0 ? DIV0_Q : '0;
        r <= divisor == '0 ? dividend : '0;
        dvd <= dividend;
        d <= divisor;
        cnt <= '0;
      end
    end else if (state == CALC) begin
      r <= co ? t[W-1:0] : r9[W-1:0];
      q <= {q[W-2:0], co};
      dvd <= dvd << 1;
      cnt <= cnt + 4'd1;
      if (cnt == 4'(ITER - 1)) state <= DONE;
    end else
      state <= IDLE;
  assign busy = state == CALC || state == DONE;
  assign done = state == DONE;
  assign quotient = q;
  assign remainder = r;
`ifdef X8_APPROX_DIV_STATS_EN
  always_ff @(posedge clk)
    if (reset) op_count <= '0;
    else if (state == DONE) op_count <= op_count + 16'd1;
`endif
endmodule

// File: tb/tb_x8_approx_div.sv
// tb_x8_approx_div: checks an exact (N4=0) and an approximate (N4=2) divider against reference models.
`timescale 1ns/1ps
module tb_x8_approx_div;
  logic clk = 1'b0;
  logic reset, start;
  logic [7:0] dividend, divisor;
  logic busy0, done0, busy2, done2;
  logic [7:0] q0, r0, q2, r2;
`ifdef X8_APPROX_DIV_STATS_EN
  logic [15:0] oc0, oc2;
`endif
  int tests = 0;
  int fails = 0;
  logic [7:0] dir_a [10] = '{8'd100, 8'd255, 8'd3, 8'd5, 8'd12, 8'd0, 8'd0, 8'd255, 8'd1, 8'd128};
  logic [7:0] dir_b [10] = '{8'd7, 8'd1, 8'd200, 8'd0, 8'd4, 8'd0, 8'd9, 8'd255, 8'd1, 8'd3};

  always #5 clk = ~clk;

  x8_approx_div #(.N4(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy0), .done(done0), .quotient(q0), .remainder(r0)
`ifdef X8_APPROX_DIV_STATS_EN
    , .op_count(oc0)
`endif
  );

  x8_approx_div #(.N4(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy2), .done(done2), .quotient(q2), .remainder(r2)
`ifdef X8_APPROX_DIV_STATS_EN
    , .op_count(oc2)
`endif
  );

  // Low n4 bits: OR sum, carry out of the top approximate bit is a&b; the rest is plain addition.
  function automatic logic [9:0] model_sub(input logic [8:0] a, input logic [8:0] b, input int n4);
    int c, hi;
    logic [8:0] lo;
    lo = (a | b) & 9'((1 << n4) - 1);
    c = n4 == 0 ? 1 : (((int'(a) & int'(b)) >> (n4 - 1)) & 1);
    hi = int'(a >> n4) + int'(b >> n4) + c;
    return 10'(hi << n4) | {1'b0, lo};
  endfunction

  function automatic logic [15:0] model_div(input logic [7:0] a, input logic [7:0] dv, input int n4);
    logic [7:0] q, r;
    logic [8:0] r9;
    logic [9:0] t;
    if (dv == 8'd0) return {8'hFF, a};
    q = '0;
    r = '0;
    for (int k = 7; k >= 0; k--) begin
      r9 = {r, a[k]};
      t = model_sub(r9, ~{1'b0, dv}, n4);
      q = {q[6:0], t[9]};
      r = t[9] ? t[7:0] : r9[7:0];
    end
    return {q, r};
  endfunction

  // Starts one operation from IDLE at a negedge; returns at the negedge where done is seen.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit poke, output int lat, output bit bz);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(negedge clk);
    start = 1'b0;
    dividend = 8'($urandom);
    divisor = 8'($urandom);
    lat = 0;
    bz = busy0 & busy2;
    while (!done0 && lat < 20) begin
      start = (poke && lat < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
      dividend = 8'($urandom);
      divisor = 8'($urandom);
      @(negedge clk);
      lat++;
      bz = bz & busy0 & busy2;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    dividend = 8'h55;
    divisor = 8'h03;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    tests++;
    if ({busy0, done0, busy2, done2} !== 4'b0) begin
      fails++;
      $display("FAIL reset_flags: busy/done %b, required 0000", {busy0, done0, busy2, done2});
    end
    tests++;
    if ({q0, r0, q2, r2} !== 32'h0) begin
      fails++;
      $display("FAIL reset_data: q/r %h, required 00000000", {q0, r0, q2, r2});
    end
`ifdef X8_APPROX_DIV_STATS_EN
    tests++;
    if ({oc0, oc2} !== 32'h0) begin
      fails++;
      $display("FAIL reset_opcount: %h, required 0", {oc0, oc2});
    end
`endif
  endtask

  task automatic test_divide();
    int lat;
    bit bz;
    logic [7:0] a, b, eq, er;
    logic [15:0] m2;
    for (int k = 0; k < 50; k++) begin
      if (k < 10) begin
        a = dir_a[k];
        b = dir_b[k];
      end else begin
        a = 8'($urandom);
        b = $urandom_range(0, 7) == 0 ? 8'd0 : 8'($urandom);
      end
      run_op(a, b, k >= 10, lat, bz);
      eq = b == 8'd0 ? 8'hFF : a / b;
      er = b == 8'd0 ? a : a % b;
      m2 = model_div(a, b, 2);
      tests++;
      if (lat != (b == 8'd0 ? 0 : 8)) begin
        fails++;
        $display("FAIL latency %0d/%0d: got %0d cycles, required %0d", a, b, lat, b == 8'd0 ? 0 : 8);
      end
      tests++;
      if (!bz) begin
        fails++;
        $display("FAIL busy %0d/%0d: busy dropped during operation, required high", a, b);
      end
      tests++;
      if (done2 !== 1'b1) begin
        fails++;
        $display("FAIL done_n4 %0d/%0d: done %b, required 1", a, b, done2);
      end
      tests++;
      if ({q0, r0} !== {eq, er}) begin
        fails++;
        $display("FAIL exact %0d/%0d: got q=%0d r=%0d, required q=%0d r=%0d", a, b, q0, r0, eq, er);
      end
      tests++;
      if ({q2, r2} !== m2) begin
        fails++;
        $display("FAIL approx %0d/%0d: got q=%0d r=%0d, required q=%0d r=%0d", a, b, q2, r2, m2[15:8], m2[7:0]);
      end
      if (a == 8'd12 && b == 8'd4) begin
        tests++;
        if ({q2, r2} !== {8'd3, 8'd3}) begin
          fails++;
          $display("FAIL approx_12_4: got q=%0d r=%0d, required q=3 r=3", q2, r2);
        end
      end
      @(negedge clk);
      tests++;
      if ({busy0, done0} !== 2'b00) begin
        fails++;
        $display("FAIL idle %0d/%0d: busy/done %b, required 00", a, b, {busy0, done0});
      end
      tests++;
      if ({q0, r0} !== {eq, er}) begin
        fails++;
        $display("FAIL hold %0d/%0d: got q=%0d r=%0d, required q=%0d r=%0d", a, b, q0, r0, eq, er);
      end
    end
  endtask

  task automatic test_abort();
    int lat;
    bit bz, seen;
    logic [15:0] m2;
    start = 1'b1;
    dividend = 8'd100;
    divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    tests++;
    if ({busy0, done0, busy2, done2} !== 4'b0) begin
      fails++;
      $display("FAIL abort_flags: busy/done %b, required 0000", {busy0, done0, busy2, done2});
    end
    tests++;
    if ({q0, r0, q2, r2} !== 32'h0) begin
      fails++;
      $display("FAIL abort_data: q/r %h, required 00000000", {q0, r0, q2, r2});
    end
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | done0 | done2 | busy0;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL abort_quiet: activity seen after abort, required none");
    end
    run_op(8'd9, 8'd3, 1'b1, lat, bz);
    m2 = model_div(8'd9, 8'd3, 2);
    tests++;
    if (lat != 8) begin
      fails++;
      $display("FAIL abort_latency: got %0d, required 8", lat);
    end
    tests++;
    if ({q0, r0} !== {8'd3, 8'd0}) begin
      fails++;
      $display("FAIL abort_result: got q=%0d r=%0d, required q=3 r=0", q0, r0);
    end
    tests++;
    if ({q2, r2} !== m2) begin
      fails++;
      $display("FAIL abort_approx: got q=%0d r=%0d, required q=%0d r=%0d", q2, r2, m2[15:8], m2[7:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int c, n;
    int when [3];
    when = '{0, 0, 0};
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    dividend = 8'd200;
    divisor = 8'd9;
    c = 0;
    n = 0;
    while (n < 3 && c < 60) begin
      @(negedge clk);
      c++;
      if (done0) begin
        when[n] = c;
        n++;
        tests++;
        if ({q0, r0} !== {8'd22, 8'd2}) begin
          fails++;
          $display("FAIL b2b_result: got q=%0d r=%0d, required q=22 r=2", q0, r0);
        end
      end
    end
    start = 1'b0;
    tests++;
    if (n != 3) begin
      fails++;
      $display("FAIL b2b_count: got %0d done pulses, required 3", n);
    end
    tests++;
    if (when[0] != 9 || when[1] != 19 || when[2] != 29) begin
      fails++;
      $display("FAIL b2b_timing: done at %0d,%0d,%0d, required 9,19,29", when[0], when[1], when[2]);
    end
    @(negedge clk);
`ifdef X8_APPROX_DIV_STATS_EN
    tests++;
    if (oc0 !== 16'd3 || oc2 !== 16'd3) begin
      fails++;
      $display("FAIL op_count: got %0d/%0d, required 3", oc0, oc2);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++;
    if (oc0 !== 16'd0 || oc2 !== 16'd0) begin
      fails++;
      $display("FAIL op_count_reset: got %0d/%0d, required 0", oc0, oc2);
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    test_reset();
    test_divide();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
